// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared state encoding and fetch-source codes for the fetch path
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_e;

    localparam logic [1:0] FSRC_RST = 2'b00;
    localparam logic [1:0] FSRC_SEQ = 2'b01;
    localparam logic [1:0] FSRC_JMP = 2'b10;
    localparam logic [1:0] FSRC_EXC = 2'b11;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_next.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_next
//  Brief    : Combinational next-PC / next-source mux (redirect > increment > hold)
//  Revision : 1.0  initial release
// ============================================================================
module fetch_pc_next
    import fetch_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int          INC     = 4,
    parameter logic [31:0] EXC_VEC = 32'h0000_0180
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        fetch_src,
    input  logic              redirect,
    input  logic              advance,
    input  logic              exc,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc_next,
    output logic [1:0]        fetch_src_next
);

    localparam logic [ADDR_W-1:0] C_EXC_PC = ADDR_W'(EXC_VEC);
    localparam logic [ADDR_W-1:0] C_INC    = ADDR_W'(INC);

    always_comb begin
        pc_next        = pc;
        fetch_src_next = fetch_src;
        // A redirect implies one of exc/jmp/br_taken is set, so br is the fallback.
        if (redirect) begin
            if (exc) begin
                pc_next        = C_EXC_PC;
                fetch_src_next = FSRC_EXC;
            end else if (jmp) begin
                pc_next        = jmp_target;
                fetch_src_next = FSRC_JMP;
            end else begin
                pc_next        = br_target;
                fetch_src_next = FSRC_JMP;
            end
        end else if (advance) begin
            pc_next        = pc + C_INC;
            fetch_src_next = FSRC_SEQ;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Brief    : PC owner and instruction-fetch request sequencer for the IF stage
//  Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] RST_VEC = '0,
    parameter logic [31:0]       EXC_VEC = 32'h0000_0180,
    parameter int                INC     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              imem_ready,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              exc,
    output logic              fetch,
    output logic              extend,
    output logic [1:0]        fetch_src,
    output logic [ADDR_W-1:0] pc,
    output logic              if_valid
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        fetch_src_q, fetch_src_d;
    logic              fetch_q, fetch_d;
    logic              extend_q, extend_d;
    logic              if_valid_q, if_valid_d;

    logic w_accept;
    logic w_redirect;
    logic w_advance;

    assign w_accept   = fetch_q & imem_ready;
    // BOOT ignores redirects entirely.
    assign w_redirect = (state_q != ST_BOOT) & (exc | jmp | br_taken);

    always_comb begin
        state_d    = state_q;
        w_advance  = 1'b0;
        if_valid_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if (w_accept) begin
                    state_d    = ST_RUN;
                    w_advance  = 1'b1;
                    if_valid_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_redirect) begin
                    state_d = ST_FLUSH;
                end else if (stall) begin
                    state_d = ST_HOLD;
                end else if (w_accept) begin
                    w_advance  = 1'b1;
                    if_valid_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_redirect) begin
                    state_d = ST_FLUSH;
                end else if (!stall) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // The redirected fetch is not delivered as valid; stall waits for RUN.
                if (w_redirect) begin
                    state_d = ST_FLUSH;
                end else if (w_accept) begin
                    state_d   = ST_RUN;
                    w_advance = 1'b1;
                end
            end
            default: state_d = ST_BOOT;
        endcase
        fetch_d  = (state_d != ST_HOLD);
        extend_d = (state_d == ST_BOOT) || (state_d == ST_FLUSH);
    end

    fetch_pc_next #(
        .ADDR_W  (ADDR_W),
        .INC     (INC),
        .EXC_VEC (EXC_VEC)
    ) u_pc_next (
        .pc             (pc_q),
        .fetch_src      (fetch_src_q),
        .redirect       (w_redirect),
        .advance        (w_advance),
        .exc            (exc),
        .jmp            (jmp),
        .jmp_target     (jmp_target),
        .br_target      (br_target),
        .pc_next        (pc_d),
        .fetch_src_next (fetch_src_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RST_VEC;
            fetch_src_q <= FSRC_RST;
            fetch_q     <= 1'b1;
            extend_q    <= 1'b1;
            if_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_src_q <= fetch_src_d;
            fetch_q     <= fetch_d;
            extend_q    <= extend_d;
            if_valid_q  <= if_valid_d;
        end
    end

    assign fetch     = fetch_q;
    assign extend    = extend_q;
    assign fetch_src = fetch_src_q;
    assign pc        = pc_q;
    assign if_valid  = if_valid_q;

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Parametrised instruction-fetch sequencer for the MIPS front end. It owns the program counter and drives instruction-memory fetch requests, starting with a boot fetch from the reset vector. It handles memory wait, pipeline stall, and branch, jump and exception redirects. Its control outputs go to the IF stage, and its valid flag goes to the IF/ID register.

## Interface
- `ADDR_W`, 32, PC/address width (≥ 8)
- `RST_VEC`, 0, boot fetch address
- `EXC_VEC`, 32'h0000_0180, exception handler address (truncated to `ADDR_W`)
- `INC`, 4, sequential PC increment
- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `stall` in 1: hazard-unit hold; freezes PC and suppresses fetch
- `imem_ready` in 1: memory accepts the current request this cycle
- `br_taken` in 1, `br_target` in ADDR_W: branch redirect (single-cycle pulse)
- `jmp` in 1, `jmp_target` in ADDR_W: jump redirect (pulse)
- `exc` in 1: exception redirect to `EXC_VEC` (pulse)
- `fetch` out 1: fetch request valid at `pc`
- `extend` out 1: current request is the first fetch after boot or a redirect
- `fetch_src` out 2: origin of current `pc`: 00 reset, 01 sequential, 10 branch/jump, 11 exception
- `pc` out ADDR_W: fetch address
- `if_valid` out 1: instruction returned to IF/ID this cycle is valid

## Operation
- accept = `fetch` & `imem_ready`.
- Redirect priority: `exc` > `jmp` > `br_taken`. Redirects override `stall` and `imem_ready`; any in-flight request is abandoned.
- States:
  - BOOT: `fetch`=1, `extend`=1, `fetch_src`=00, `pc`=`RST_VEC`. On accept → RUN, `pc`←`pc`+`INC`, `fetch_src`←01. Otherwise stay. Redirects and `stall` are ignored in BOOT.
  - RUN: `fetch`=1, `extend`=0.
    - redirect → FLUSH; `pc`←target; `fetch_src`←10, or 11 for `exc`.
    - else `stall` → HOLD; `pc` held.
    - else accept → `pc`←`pc`+`INC`, `fetch_src`←01.
    - else no change (memory wait).
  - HOLD: `fetch`=0, `pc` held.
    - redirect → FLUSH, as in RUN.
    - `stall` low → RUN.
  - FLUSH: `fetch`=1, `extend`=1, `if_valid` forced 0.
    - redirect → FLUSH again with the new target.
    - accept → RUN, `pc`←`pc`+`INC`, `fetch_src`←01.
    - `stall` is honoured only after leaving FLUSH.
    - otherwise stay.
- `if_valid` is a register. It is set the cycle after an accept in RUN or BOOT with no redirect in that cycle; otherwise it is cleared.
- Arithmetic: `pc`+`INC` wraps modulo 2^`ADDR_W`. Targets are used unmodified (no alignment masking).
- Simultaneous events:
  - redirect + accept: the redirect wins and `if_valid` next cycle is 0.
  - `stall` + accept in RUN: the stall wins and the PC does not advance.

## Timing
- Reset values: state=BOOT, `pc`=`RST_VEC`, `fetch_src`=00, `fetch`=1, `extend`=1, `if_valid`=0.
- Asserting `rst` at any point returns the block to these values immediately. Memory ignores `fetch` while `rst` is high.
- `fetch`, `extend` and `fetch_src` are pure functions of state and registers (Moore); they have no combinational path from inputs.
- Redirect latency: pulse at cycle N → `pc`=target and `extend`=1 at N+1.
- Fetch → `if_valid` latency: 1 cycle.
- Back-to-back accepts sustain one fetch per cycle.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum: BOOT, RUN, HOLD, FLUSH;
  - the `fetch_src` constants: FSRC_RST=00, FSRC_SEQ=01, FSRC_JMP=10, FSRC_EXC=11.
- Sub-module `fetch_pc_next`: combinational next-PC mux (priority redirect, increment, hold), parametrised by `ADDR_W`, `INC`, `EXC_VEC`. The FSM and registers stay in `fetch_sequencer`.

## Test plan
- Boot: release `rst` with `imem_ready`=1 → `pc` sequence 0, 4, 8; `extend`=1 only on the first cycle; `if_valid` first high one cycle after release; `fetch_src` 00 then 01.
- Memory wait: hold `imem_ready`=0 for 3 cycles in RUN at `pc`=0x10 → `pc` stays 0x10 and `if_valid`=0; resumes to 0x14 the cycle after `imem_ready`=1.
- Stall: `stall` high 2 cycles at `pc`=0x20 → `fetch`=0 during HOLD, `pc`=0x20, then `fetch`=1 at 0x20 and advances to 0x24 once accepted.
- Redirect priority: `exc`, `jmp` (0x400) and `br_taken` (0x800) in the same cycle → next `pc`=0x180, `fetch_src`=11, `extend`=1, `if_valid`=0.
- Redirect during HOLD and during FLUSH: branch to 0x100, then jump to 0x200 the next cycle → `pc`=0x200, `fetch_src`=10, no valid instruction from 0x100.
- Wrap and async reset: `ADDR_W`=8, `pc`=0xFC, accept → `pc`=0x00. Assert `rst` mid-FLUSH → immediate BOOT values without waiting for a clock edge.
